pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the 5-stage Y86-64 pipeline. Drives stall/bubble controls for the
//  F/D/E/M/W pipeline registers and the condition-code write enable.
//  Holds a run-state FSM (power-up flush, run, halted), latches the final CPU status,
//  and keeps retire/cycle counters. Sits beside the pipeline registers; its inputs are their outputs.
// PARAMETERS
//  FLUSH_CYCLES  4   cycles of forced bubbles after reset release (>=1)
//  CNT_W         32  width of every counter
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst_n          in   1      asynchronous active-low reset
//  D_icode        in   4      icode in D register
//  d_srcA,d_srcB  in   4,4    decode source regs (4'hF = none)
//  E_icode        in   4      icode in E register
//  E_dstM         in   4      load destination in E register
//  e_Cnd          in   1      execute-stage branch condition
//  M_icode        in   4      icode in M register
//  m_stat         in   3      memory-stage status
//  W_stat         in   3      W register status
//  W_icode        in   4      W register icode
//  F_stall,D_stall,W_stall   out 1 each  hold register contents
//  D_bubble,E_bubble,M_bubble out 1 each  load nop/bubble into register
//  set_cc         out  1      CC write enable
//  halted         out  1      FSM in HALTED
//  cpu_stat       out  3      latched final status
//  cycle_cnt      out  CNT_W  RUN cycles
//  retired_cnt    out  CNT_W  retired instructions
//  lu_cnt,mp_cnt,ret_cnt out CNT_W each  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  Codes: SAOK=1 SHLT=2 SADR=3 SINS=4; IJXX=7 IOPQ=6 IMRMOVQ=5 IPOPQ=B IRET=9 INOP=1.
//  exc(s) = (s != SAOK).
//  FSM states INIT -> RUN -> HALTED; reset forces INIT. Only reset leaves HALTED.
//  INIT: flush counter loads 0, increments each cycle; INIT->RUN at the edge where it reaches FLUSH_CYCLES-1.
//   Outputs: F_stall=1, D_bubble=E_bubble=M_bubble=1, others 0; inputs ignored (regs may hold X).
//  RUN: combinational, same-cycle:
//   lu  = E_icode in {IMRMOVQ,IPOPQ} && E_dstM!=4'hF && E_dstM in {d_srcA,d_srcB}
//   ret = IRET in {D_icode,E_icode,M_icode}
//   mp  = E_icode==IJXX && !e_Cnd
//   F_stall=lu|ret; D_stall=lu; D_bubble=mp|(ret&!lu); E_bubble=mp|lu
//   M_bubble=exc(m_stat)|exc(W_stat); W_stall=exc(W_stat)
//   set_cc=E_icode==IOPQ && !exc(m_stat) && !exc(W_stat)
//   Stall has priority over bubble on D: never D_stall&D_bubble together.
//   RUN->HALTED when exc(W_stat); cpu_stat<=W_stat at that edge.
//  HALTED: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1.
//  Reset values: state INIT, cpu_stat=SAOK, halted=0, all counters 0.
//   While rst_n low, outputs are the INIT values.
//  cycle_cnt +1 each RUN cycle.
//  retired_cnt +1 on RUN cycles with W_stat==SAOK && W_icode!=INOP && !W_stall. Real nops are not counted.
//  All counters saturate at all-ones; no wrap.
//  Reset mid-run: all state and counters clear asynchronously; FLUSH repeats.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined, counting RUN cycles only:
//   lu_cnt +1 per lu cycle
//   mp_cnt +1 per mp cycle
//   ret_cnt +1 per ret&!lu cycle
//  Undefined: lu_cnt, mp_cnt and ret_cnt tied to 0, no counter flops. Ports are present in both builds.
// TESTING
//  Reset: rst_n low 3 cyc, release -> F_stall=1 and D/E/M_bubble=1 for exactly 4 cycles, then all 0.
//   With E_icode=6 -> set_cc=1.
//  Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0, lu_cnt+1.
//   Same with E_dstM=F -> all 0.
//  Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0.
//   e_Cnd=1 -> all 0.
//  Ret + load-use: D_icode=9, E_icode=B, E_dstM=d_srcB=4 -> F_stall=D_stall=E_bubble=1, D_bubble=0.
//  Halt: m_stat=2 -> M_bubble=1, set_cc=0 same cycle.
//   Next W_stat=2 -> W_stall=1; following edge halted=1, cpu_stat=2, cycle_cnt/retired_cnt frozen.
//  Saturation (CNT_W=4): 20 RUN cycles with W_icode=6, W_stat=1 -> cycle_cnt=retired_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage pipeline control: hazard stall/bubble generation, run-state FSM, status latch and counters.
// Optional per-hazard performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam int         FW      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t        state_reg, state_next;
  logic [FW-1:0] flush_reg;

  logic lu, ret, mp, m_exc, w_exc, in_run;

  // Hazard detection, evaluated every cycle; only RUN lets it reach the outputs.
  assign lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret    = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mp     = (E_icode == IJXX) && !e_Cnd;
  assign m_exc  = (m_stat != SAOK);
  assign w_exc  = (W_stat != SAOK);
  assign in_run = (state_reg == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      flush_reg <= '0;
      cpu_stat  <= SAOK;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_INIT)
        flush_reg <= flush_reg + FW'(1);
      if (in_run && w_exc)
        cpu_stat <= W_stat;
    end
  end

  always_comb begin
    state_next = state_reg;
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    W_stall    = 1'b0;
    D_bubble   = 1'b0;
    E_bubble   = 1'b0;
    M_bubble   = 1'b0;
    set_cc     = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_INIT: begin
        // Pipeline registers may hold garbage here, so every input is ignored.
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (flush_reg == FW'(FLUSH_CYCLES - 1))
          state_next = S_RUN;
      end
      S_RUN: begin
        F_stall  = lu | ret;
        D_stall  = lu;
        D_bubble = !lu && (mp || ret);
        E_bubble = mp | lu;
        M_bubble = m_exc | w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
        if (w_exc)
          state_next = S_HALTED;
      end
      S_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        halted   = 1'b1;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  logic retire;
  assign retire = in_run && (W_stat == SAOK) && (W_icode != INOP) && !W_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (in_run && (cycle_cnt != CNT_MAX))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && (retired_cnt != CNT_MAX))
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Index 0: load-use, 1: mispredict, 2: return bubble (suppressed when load-use wins).
  logic [2:0]       perf_ev;
  logic [CNT_W-1:0] perf_cnt [3];

  assign perf_ev = {in_run && ret && !lu, in_run && mp, in_run && lu};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          perf_cnt[gi] <= '0;
        else if (perf_ev[gi] && (perf_cnt[gi] != CNT_MAX))
          perf_cnt[gi] <= perf_cnt[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign lu_cnt  = perf_cnt[0];
  assign mp_cnt  = perf_cnt[1];
  assign ret_cnt = perf_cnt[2];
`else
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign ret_cnt = '0;
`endif

  a_no_stall_and_bubble: assert property (@(posedge clk) disable iff (!rst_n)
    !(D_stall && D_bubble));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam logic [6:0] INIT_CTL = 7'b1001110; // {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc}

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
  logic [2:0] cpu_stat;
  logic [CW-1:0] cycle_cnt, retired_cnt, lu_cnt, mp_cnt, ret_cnt;

  pipe_ctrl #(.FLUSH_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .halted(halted), .cpu_stat(cpu_stat),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    ctl;
    logic          halt;
    logic [2:0]    stat;
    logic [CW-1:0] cyc;
    logic [CW-1:0] rtd;
    logic [CW-1:0] lu;
    logic [CW-1:0] mp;
    logic [CW-1:0] rt;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    errors = 0;
  int    txn = 0;
  int    m_cyc = 0, m_rtd = 0, m_lu = 0, m_mp = 0, m_rt = 0;

  function automatic int sat(input int v);
    return (v < 15) ? v + 1 : v;
  endfunction

  task automatic idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
    M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; W_icode = 4'h1;
  endtask

  // mode: 0 = reset/flush, 1 = run, 2 = halted; perf = {lu, mp, ret-bubble} events this cycle.
  task automatic step(input logic r, input logic [6:0] ctl, input int mode,
                      input logic [2:0] perf, input logic [2:0] stat, input string tag);
    exp_t e;
    rst_n = r;
    if (!r) begin
      m_cyc = 0; m_rtd = 0; m_lu = 0; m_mp = 0; m_rt = 0;
    end
    e.ctl  = ctl;
    e.halt = (mode == 2);
    e.stat = stat;
    e.cyc  = CW'(m_cyc);
    e.rtd  = CW'(m_rtd);
`ifdef PIPE_CTRL_PERF_EN
    e.lu = CW'(m_lu); e.mp = CW'(m_mp); e.rt = CW'(m_rt);
`else
    e.lu = '0; e.mp = '0; e.rt = '0;
`endif
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (mode == 1) begin
      m_cyc = sat(m_cyc);
      if (W_stat == 3'd1 && W_icode != 4'h1 && !ctl[4]) m_rtd = sat(m_rtd);
      if (perf[2]) m_lu = sat(m_lu);
      if (perf[1]) m_mp = sat(m_mp);
      if (perf[0]) m_rt = sat(m_rt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  exp_t  me;
  string mt;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      mt = tag_q.pop_front();
      txn++;
      chk({mt, ".ctl"}, 32'({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}), 32'(me.ctl));
      chk({mt, ".halted"}, 32'(halted), 32'(me.halt));
      chk({mt, ".cpu_stat"}, 32'(cpu_stat), 32'(me.stat));
      chk({mt, ".cycle_cnt"}, 32'(cycle_cnt), 32'(me.cyc));
      chk({mt, ".retired_cnt"}, 32'(retired_cnt), 32'(me.rtd));
      chk({mt, ".lu_cnt"}, 32'(lu_cnt), 32'(me.lu));
      chk({mt, ".mp_cnt"}, 32'(mp_cnt), 32'(me.mp));
      chk({mt, ".ret_cnt"}, 32'(ret_cnt), 32'(me.rt));
      $display("txn %0d %s ctl=%b halted=%b stat=%0d cyc=%0d ret=%0d", txn, mt,
               {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc},
               halted, cpu_stat, cycle_cnt, retired_cnt);
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, INIT_CTL, 0, 3'b000, 3'd1, "reset");
    E_icode = 4'h6; d_srcA = 4'h3; E_dstM = 4'h3;
    repeat (4) step(1'b1, INIT_CTL, 0, 3'b000, 3'd1, "flush");

    idle(); E_icode = 4'h6; W_icode = 4'h6;
    step(1'b1, 7'b0000001, 1, 3'b000, 3'd1, "opq_setcc");
    idle();
    step(1'b1, 7'b0000000, 1, 3'b000, 3'd1, "idle");
    idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h2;
    step(1'b1, 7'b1100100, 1, 3'b100, 3'd1, "load_use");
    idle(); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
    step(1'b1, 7'b0000000, 1, 3'b000, 3'd1, "load_none");
    idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    step(1'b1, 7'b1100100, 1, 3'b100, 3'd1, "pop_use");
    idle(); E_icode = 4'h7; e_Cnd = 1'b0;
    step(1'b1, 7'b0001100, 1, 3'b010, 3'd1, "mispredict");
    idle(); E_icode = 4'h7; e_Cnd = 1'b1;
    step(1'b1, 7'b0000000, 1, 3'b000, 3'd1, "jmp_taken");
    idle(); D_icode = 4'h9;
    step(1'b1, 7'b1001000, 1, 3'b001, 3'd1, "ret_d");
    idle(); M_icode = 4'h9;
    step(1'b1, 7'b1001000, 1, 3'b001, 3'd1, "ret_m");
    idle(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    step(1'b1, 7'b1100100, 1, 3'b100, 3'd1, "ret_lu");
    idle(); E_icode = 4'h7; M_icode = 4'h9;
    step(1'b1, 7'b1001100, 1, 3'b011, 3'd1, "mp_ret");

    idle(); W_icode = 4'h6;
    repeat (20) step(1'b1, 7'b0000000, 1, 3'b000, 3'd1, "saturate");

    idle(); m_stat = 3'd2; E_icode = 4'h6;
    step(1'b1, 7'b0000010, 1, 3'b000, 3'd1, "m_halt");
    idle(); W_stat = 3'd2; W_icode = 4'h0; E_icode = 4'h6;
    step(1'b1, 7'b0010010, 1, 3'b000, 3'd1, "w_halt");
    idle(); W_icode = 4'h6; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    repeat (3) step(1'b1, 7'b1110110, 2, 3'b000, 3'd2, "halted");

    idle();
    repeat (2) step(1'b0, INIT_CTL, 0, 3'b000, 3'd1, "reset_mid");
    repeat (4) step(1'b1, INIT_CTL, 0, 3'b000, 3'd1, "reflush");
    idle(); W_icode = 4'h6;
    step(1'b1, 7'b0000000, 1, 3'b000, 3'd1, "rerun");
    idle(); m_stat = 3'd4; E_icode = 4'h6; W_icode = 4'h6;
    step(1'b1, 7'b0000010, 1, 3'b000, 3'd1, "m_sins");
    idle(); W_stat = 3'd3; W_icode = 4'h5;
    step(1'b1, 7'b0010010, 1, 3'b000, 3'd1, "w_sadr");
    idle(); W_icode = 4'h6;
    repeat (2) step(1'b1, 7'b1110110, 2, 3'b000, 3'd3, "halted_sadr");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
